// File: rtl/image_pkg.sv
// Shared types and default geometry for the image loader slice.
package image_pkg;
   localparam int IMAGE_NUM  = 10;
   localparam int IMAGE_SIZE = 6;
   localparam int DATA_WIDTH = 16;
   localparam int TAG_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   // One pixel slot as it travels through the skid FIFO.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  row;
      logic [TAG_WIDTH-1:0]  col;
      logic                  last;
   } pix_t;
endpackage

// File: rtl/image_loader_if.sv
// ROM read port plus tagged pixel stream between the loader and its neighbours.
interface image_loader_if #(
   parameter int DATA_WIDTH = image_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(image_pkg::IMAGE_NUM * image_pkg::IMAGE_SIZE * image_pkg::IMAGE_SIZE)
);
   logic                  rom_rd;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  pix_valid;
   logic                  pix_ready;
   logic [DATA_WIDTH-1:0] pix_data;
   logic [7:0]            pix_row;
   logic [7:0]            pix_col;
   logic                  pix_last;

   modport master (
      output rom_rd, rom_addr, pix_valid, pix_data, pix_row, pix_col, pix_last,
      input  rom_data, pix_ready
   );

   modport slave (
      input  rom_rd, rom_addr, pix_valid, pix_data, pix_row, pix_col, pix_last,
      output rom_data, pix_ready
   );
endinterface

// File: rtl/image_skid_fifo.sv
// Two-entry FIFO of tagged pixels; the head entry drives the stream outputs.
module image_skid_fifo
   import image_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  pix_t       push_data,
   input  logic       pop,
   output pix_t       head,
   output logic [1:0] count
);
   pix_t       mem_q [2];
   pix_t       mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;

   // Pointer and occupancy update; push and pop in one cycle leave count unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Storage and pointers; entries clear on reset so the outputs read zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/image_loader.sv
// Streams one image from ROM in raster order as a tagged valid/ready pixel stream.
// Optional IMAGE_LOADER_ZERO_PAD_EN adds a one-pixel zero border around the frame.
module image_loader
   import image_pkg::*;
#(
   parameter int IMAGE_NUM  = image_pkg::IMAGE_NUM,
   parameter int IMAGE_SIZE = image_pkg::IMAGE_SIZE,
   parameter int DATA_WIDTH = image_pkg::DATA_WIDTH,  // pix_t carries the package width
   parameter int ADDR_WIDTH = $clog2(IMAGE_NUM * IMAGE_SIZE * IMAGE_SIZE)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [3:0]     image_idx,
   output logic           busy,
   output logic           frame_done,
   image_loader_if.master bus
);
`ifdef IMAGE_LOADER_ZERO_PAD_EN
   localparam int LAST_IDX = IMAGE_SIZE + 1;
`else
   localparam int LAST_IDX = IMAGE_SIZE - 1;
`endif
   localparam logic [7:0] LAST_TAG = 8'(LAST_IDX);

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [7:0]            row_q, row_d;
   logic [7:0]            col_q, col_d;
   logic                  slot_vld_q, slot_vld_d;
   logic                  slot_border_q, slot_border_d;
   pix_t                  slot_q, slot_d;

   pix_t                  push_data, head;
   logic [1:0]            count, credit;
   logic                  pop, issue, last_slot, border;
   logic [ADDR_WIDTH-1:0] addr;

   // Slot issue: a new slot is allowed only if the FIFO, after this cycle's pop,
   // still has room for it and for the slot already in flight.
   always_comb begin
      pop       = (count != 2'd0) && bus.pix_ready;
      credit    = count - {1'b0, pop} + {1'b0, slot_vld_q};
      issue     = (state_q == FETCH) && (credit < 2'd2);
      last_slot = (row_q == LAST_TAG) && (col_q == LAST_TAG);
`ifdef IMAGE_LOADER_ZERO_PAD_EN
      border = (row_q == 8'd0) || (col_q == 8'd0) || (row_q == LAST_TAG) || (col_q == LAST_TAG);
      addr   = border ? base_q
                      : base_q + ADDR_WIDTH'((row_q - 8'd1) * IMAGE_SIZE) + ADDR_WIDTH'(col_q - 8'd1);
`else
      border = 1'b0;
      addr   = base_q + ADDR_WIDTH'(row_q * IMAGE_SIZE) + ADDR_WIDTH'(col_q);
`endif
   end

   // Frame sequencing: latch the image base, walk row/col, wait for the last handshake.
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      base_d  = base_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (start && (int'(image_idx) < IMAGE_NUM)) begin
               state_d = FETCH;
               busy_d  = 1'b1;
               base_d  = ADDR_WIDTH'(int'(image_idx) * IMAGE_SIZE * IMAGE_SIZE);
               row_d   = 8'd0;
               col_d   = 8'd0;
            end
         end
         FETCH: begin
            if (issue) begin
               if (last_slot) state_d = DRAIN;
               if (col_q == LAST_TAG) begin
                  col_d = 8'd0;
                  row_d = row_q + 8'd1;
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end
         DRAIN: begin
            if (pop && head.last) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM registers and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         base_q  <= '0;
         row_q   <= 8'd0;
         col_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         base_q  <= base_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Tags for the slot issued this cycle, matched with ROM data one cycle later.
   always_comb begin
      slot_vld_d    = issue;
      slot_border_d = border;
      slot_d        = '{data: '0, row: row_q, col: col_q, last: last_slot};
   end

   // In-flight slot register; reset drops any read whose data is still on its way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_vld_q    <= 1'b0;
         slot_border_q <= 1'b0;
         slot_q        <= '0;
      end else begin
         slot_vld_q    <= slot_vld_d;
         slot_border_q <= slot_border_d;
         slot_q        <= slot_d;
      end
   end

   // Border slots enter the FIFO as zeros in the same order as ROM slots.
   always_comb begin
      push_data      = slot_q;
      push_data.data = slot_border_q ? '0 : bus.rom_data;
   end

   image_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (slot_vld_q),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign bus.rom_rd    = issue && !border;
   assign bus.rom_addr  = addr;
   assign bus.pix_valid = (count != 2'd0);
   assign bus.pix_data  = head.data;
   assign bus.pix_row   = head.row;
   assign bus.pix_col   = head.col;
   assign bus.pix_last  = head.last;
   assign busy          = busy_q;
   assign frame_done    = done_q;
endmodule

// File: tb/tb_image_loader.sv
// Directed/randomised bench for image_loader against a raster-order frame model.
module tb_image_loader;
   import image_pkg::*;

   localparam int AW = $clog2(IMAGE_NUM * IMAGE_SIZE * IMAGE_SIZE);
`ifdef IMAGE_LOADER_ZERO_PAD_EN
   localparam int W   = IMAGE_SIZE + 2;
   localparam bit PAD = 1'b1;
`else
   localparam int W   = IMAGE_SIZE;
   localparam bit PAD = 1'b0;
`endif
   localparam int NPIX = W * W;
   localparam int NRD  = IMAGE_SIZE * IMAGE_SIZE;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] image_idx = 4'd0;
   logic       busy, frame_done;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   image_loader_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(AW)) bus ();

   image_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .image_idx  (image_idx),
      .busy       (busy),
      .frame_done (frame_done),
      .bus        (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM model: word = its own address, valid only the cycle after a read strobe.
   always @(posedge clk)
      bus.rom_data <= bus.rom_rd ? DATA_WIDTH'(bus.rom_addr) : DATA_WIDTH'($urandom);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected k-th pixel of a frame, straight from the addressing rule.
   function automatic logic [31:0] exp_data(input int idx, input int k);
      int r, c;
      r = k / W;
      c = k % W;
      if (PAD) begin
         if (r == 0 || c == 0 || r == W - 1 || c == W - 1) return 32'd0;
         return 32'(idx * NRD + (r - 1) * IMAGE_SIZE + (c - 1));
      end
      return 32'(idx * NRD + r * IMAGE_SIZE + c);
   endfunction

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_rom_rd"},     32'(bus.rom_rd),    0);
      chk({pfx, "_rom_addr"},   32'(bus.rom_addr),  0);
      chk({pfx, "_pix_valid"},  32'(bus.pix_valid), 0);
      chk({pfx, "_pix_data"},   32'(bus.pix_data),  0);
      chk({pfx, "_pix_row"},    32'(bus.pix_row),   0);
      chk({pfx, "_pix_col"},    32'(bus.pix_col),   0);
      chk({pfx, "_pix_last"},   32'(bus.pix_last),  0);
      chk({pfx, "_busy"},       32'(busy),          0);
      chk({pfx, "_frame_done"}, 32'(frame_done),    0);
   endtask

   // Starts a frame and follows it; abort_after>0 stops after that many pixels.
   task automatic run_frame(input int idx, input bit rnd, input int abort_after, input bit poke_start);
      int k, n_rd, t0, t_first, t_last, t_done;
      k = 0; n_rd = 0; t_first = -1; t_last = -1; t_done = -1;
      @(negedge clk);
      start = 1'b1;
      image_idx = 4'(idx);
      bus.pix_ready = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 600 && t_done < 0; i++) begin
         @(negedge clk);
         bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke_start && i == 6) begin
            start = 1'b1;
            image_idx = 4'(idx ^ 1);
         end else begin
            start = 1'b0;
         end
         #1;
         if (i == 0) begin
            chk("busy_t1", 32'(busy), 1);
            chk("rom_rd_t1", 32'(bus.rom_rd), PAD ? 0 : 1);
         end
         if (bus.rom_rd) n_rd++;
         if (frame_done) begin
            t_done = cyc;
         end else if (bus.pix_valid) begin
            // The head must always be the next expected pixel, stalled or not.
            chk("pix_data", 32'(bus.pix_data), exp_data(idx, k));
            chk("pix_row",  32'(bus.pix_row),  32'(k / W));
            chk("pix_col",  32'(bus.pix_col),  32'(k % W));
            chk("pix_last", 32'(bus.pix_last), (k == NPIX - 1) ? 1 : 0);
            if (bus.pix_ready) begin
               if (k == 0) t_first = cyc;
               if (k == NPIX - 1) t_last = cyc;
               k++;
            end
         end
         if (abort_after > 0 && k == abort_after) break;
      end
      start = 1'b0;
      if (abort_after == 0) begin
         chk("pixel_count", 32'(k), 32'(NPIX));
         chk("rom_rd_count", 32'(n_rd), 32'(NRD));
         chk("frame_done_seen", 32'(t_done >= 0), 1);
         if (!rnd) begin
            chk("t_first_valid", 32'(t_first - t0), 3);
            chk("t_last_hs", 32'(t_last - t0), 32'(2 + NPIX));
            chk("t_frame_done", 32'(t_done - t0), 32'(3 + NPIX));
         end
         @(negedge clk);
         #1;
         chk("done_one_cycle", 32'(frame_done), 0);
         chk("busy_after_done", 32'(busy), 0);
         chk("valid_after_done", 32'(bus.pix_valid), 0);
      end
   endtask

   initial begin
      bus.pix_ready = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      // Full-rate frame from image 2 with latency checks.
      run_frame(2, 1'b0, 0, 1'b0);

      // Out-of-range index is ignored.
      @(negedge clk);
      start = 1'b1;
      image_idx = 4'd10;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("bad_idx_busy", 32'(busy), 0);
      chk("bad_idx_rom_rd", 32'(bus.rom_rd), 0);
      @(negedge clk);
      #1;
      chk("bad_idx_busy2", 32'(busy), 0);
      chk("bad_idx_valid", 32'(bus.pix_valid), 0);

      // Random back-pressure on image 0.
      run_frame(0, 1'b1, 0, 1'b0);

      // A second start mid-frame must not disturb image 5.
      run_frame(5, 1'b0, 0, 1'b1);

      // Highest valid index under back-pressure.
      run_frame(IMAGE_NUM - 1, 1'b1, 0, 1'b0);

      // Reset mid-frame, then a clean frame from (0,0).
      run_frame(1, 1'b1, 10, 1'b0);
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy_after", 32'(busy), 0);
      run_frame(1, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
